d_card: RTL and testbench

Card-side model of the SD 4-bit DAT bus, i.e. the responder at the opposite end of the data lines from `d_driver`. On request it transmits one 512-byte block from a local nibble buffer with per-line CRC16. It also receives one block from the host into that buffer, checks the CRC and answers with a CRC status token followed by an optional busy phase. It sits in the simulation/FPGA card emulator next to the command-line responder and lets the host transceiver be exercised in closed loop.

---
 rtl/d_card_if.sv | 23 ++
 rtl/d_card.sv | 239 +++++++++++++++++++++++
 tb/tb_d_card.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/d_card_if.sv
// SD 4-bit DAT bus plus local nibble-buffer port, as seen by the card-side responder d_card.
interface d_card_if;
    logic       istart_tx;
    logic       istart_rx;
    logic [3:0] idata_sd;
    logic [3:0] odata_sd;
    logic [9:0] oaddr;
    logic [3:0] irdata;
    logic [3:0] owdata;
    logic       owrite_en;
    logic       ocrc_fail;
    logic       odone;

    modport master (
        output istart_tx, istart_rx, idata_sd, irdata,
        input  odata_sd, oaddr, owdata, owrite_en, ocrc_fail, odone
    );

    modport slave (
        input  istart_tx, istart_rx, idata_sd, irdata,
        output odata_sd, oaddr, owdata, owrite_en, ocrc_fail, odone
    );
endinterface

// File: rtl/d_card.sv
// Card-side SD DAT responder: sends/receives one 512-byte block with per-line CRC16.
// Define D_CARD_BUSY_EN to hold DAT0 low for BUSY_CYCLES after the CRC status token.
module d_card #(
    parameter int NAC         = 2,
    parameter int BUSY_CYCLES = 8
) (
    input  logic     iclk,
    input  logic     irst,
    d_card_if.slave  bus
);
    // state      | meaning
    // IDLE       | waiting for istart_tx / istart_rx
    // TX_WAIT    | NAC idle cycles before the start bit
    // TX_START   | start bit on all lines, buffer prefetch
    // TX_DATA    | 1024 data nibbles
    // TX_CRC     | 16 CRC bits per line, MSB first
    // TX_END     | end bit
    // RX_WAIT    | waiting for the host start bit
    // RX_DATA    | 1024 nibbles written to the buffer
    // RX_CRC     | 16 CRC bits compared per line
    // RX_END     | end bit check
    // ST_GAP     | 2 idle cycles before the status token
    // ST_TOKEN   | CRC status token on DAT0
    // ST_BUSY    | DAT0 held low (D_CARD_BUSY_EN only)
    // DONE       | odone pulse
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_TX_WAIT  = 4'd1;
    localparam logic [3:0] S_TX_START = 4'd2;
    localparam logic [3:0] S_TX_DATA  = 4'd3;
    localparam logic [3:0] S_TX_CRC   = 4'd4;
    localparam logic [3:0] S_TX_END   = 4'd5;
    localparam logic [3:0] S_RX_WAIT  = 4'd6;
    localparam logic [3:0] S_RX_DATA  = 4'd7;
    localparam logic [3:0] S_RX_CRC   = 4'd8;
    localparam logic [3:0] S_RX_END   = 4'd9;
    localparam logic [3:0] S_ST_GAP   = 4'd10;
    localparam logic [3:0] S_ST_TOKEN = 4'd11;
`ifdef D_CARD_BUSY_EN
    localparam logic [3:0] S_ST_BUSY  = 4'd12;
`endif
    localparam logic [3:0] S_DONE     = 4'd13;

    localparam int CNT_MAX = (BUSY_CYCLES > 1024) ? BUSY_CYCLES : 1024;
    localparam int CNT_W   = $clog2(CNT_MAX);
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    logic [3:0]        state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    logic [3:0]        odata_q, odata_d;
    logic [9:0]        addr_q, addr_d;
    logic [3:0]        wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              fail_q, fail_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [3:0][15:0]  crc_q, crc_d;
    logic [4:0]        tok;
    logic [2:0]        tok_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        odata_d = 4'hF;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        fail_d  = fail_q;
        done_d  = 1'b0;
        err_d   = err_q;
        crc_d   = crc_q;
        // token bits 0, s2, s1, s0, 1 sent from bit 4 down
        tok     = fail_q ? 5'b01011 : 5'b00101;
        tok_idx = cnt_q[2:0] - 3'd1;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (bus.istart_tx) begin
                    state_d = S_TX_WAIT;
                    cnt_d   = cnt_t'(NAC - 1);
                    fail_d  = 1'b0;
                    crc_d   = '0;
                end else if (bus.istart_rx) begin
                    state_d = S_RX_WAIT;
                    fail_d  = 1'b0;
                    err_d   = 1'b0;
                    crc_d   = '0;
                end
            end
            S_TX_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_TX_START;
                    odata_d = 4'h0;
                    addr_d  = 10'd1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_TX_START: begin
                // read data lags oaddr by a cycle and odata is registered, so fetch runs two nibbles ahead
                state_d = S_TX_DATA;
                cnt_d   = cnt_t'(1023);
                odata_d = bus.irdata;
                addr_d  = 10'd2;
            end
            S_TX_DATA: begin
                for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], odata_q[i]);
                if (cnt_q == '0) begin
                    state_d = S_TX_CRC;
                    cnt_d   = cnt_t'(15);
                    addr_d  = '0;
                    for (int i = 0; i < 4; i++) odata_d[i] = crc_d[i][15];
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                    odata_d = bus.irdata;
                    if (addr_q != 10'd1023) addr_d = addr_q + 10'd1;
                end
            end
            S_TX_CRC: begin
                for (int i = 0; i < 4; i++) crc_d[i] = {crc_q[i][14:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_TX_END;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                    for (int i = 0; i < 4; i++) odata_d[i] = crc_q[i][14];
                end
            end
            S_TX_END: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_RX_WAIT: begin
                if (bus.idata_sd == 4'h0) begin
                    state_d = S_RX_DATA;
                    cnt_d   = cnt_t'(1023);
                end
            end
            S_RX_DATA: begin
                for (int i = 0; i < 4; i++) crc_d[i] = crc_step(crc_q[i], bus.idata_sd[i]);
                wen_d   = 1'b1;
                wdata_d = bus.idata_sd;
                addr_d  = (cnt_q == cnt_t'(1023)) ? 10'd0 : addr_q + 10'd1;
                if (cnt_q == '0) begin
                    state_d = S_RX_CRC;
                    cnt_d   = cnt_t'(15);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_RX_CRC: begin
                addr_d = '0;
                for (int i = 0; i < 4; i++) begin
                    if (bus.idata_sd[i] != crc_q[i][15]) err_d = 1'b1;
                    crc_d[i] = {crc_q[i][14:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_RX_END;
                else cnt_d = cnt_q - cnt_t'(1);
            end
            S_RX_END: begin
                fail_d  = err_q | (bus.idata_sd != 4'hF);
                state_d = S_ST_GAP;
                cnt_d   = cnt_t'(1);
            end
            S_ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_ST_TOKEN;
                    cnt_d   = cnt_t'(4);
                    odata_d = {3'b111, tok[4]};
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_ST_TOKEN: begin
                if (cnt_q == '0) begin
`ifdef D_CARD_BUSY_EN
                    state_d = S_ST_BUSY;
                    cnt_d   = cnt_t'(BUSY_CYCLES - 1);
                    odata_d = 4'hE;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                    odata_d = {3'b111, tok[tok_idx]};
                end
            end
`ifdef D_CARD_BUSY_EN
            S_ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                    odata_d = 4'hE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            odata_q <= 4'hF;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            odata_q <= odata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
            err_q   <= err_d;
            crc_q   <= crc_d;
        end
    end

    assign bus.odata_sd  = odata_q;
    assign bus.oaddr     = addr_q;
    assign bus.owdata    = wdata_q;
    assign bus.owrite_en = wen_q;
    assign bus.ocrc_fail = fail_q;
    assign bus.odone     = done_q;
endmodule

// File: tb/tb_d_card.sv
// Bench for d_card: host-side driver, nibble buffer model and CRC reference model.
module tb_d_card;
    localparam int NAC  = 2;
    localparam int BUSY = 8;
`ifdef D_CARD_BUSY_EN
    localparam int BUSY_EXP = BUSY;
`else
    localparam int BUSY_EXP = 0;
`endif

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    d_card_if bus();
    d_card #(.NAC(NAC), .BUSY_CYCLES(BUSY)) dut (.iclk(iclk), .irst(irst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [1024];
    logic [3:0] rd_q;
    logic       tb_ld = 1'b0;
    logic [9:0] tb_ld_addr = '0;
    logic [3:0] tb_ld_data = '0;
    logic       wr_clr = 1'b0;
    int         wr_cnt = 0;
    logic [3:0] dat_ref [1024];
    logic [3:0] exp_q [$];

    always @(posedge iclk) begin
        if (tb_ld) mem[tb_ld_addr] <= tb_ld_data;
        else if (bus.owrite_en) mem[bus.oaddr] <= bus.owdata;
        rd_q <= mem[bus.oaddr];
        if (wr_clr) wr_cnt <= 0;
        else if (bus.owrite_en) wr_cnt <= wr_cnt + 1;
    end
    assign bus.irdata = rd_q;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_ref(input int ln);
        logic [16:0] r;
        r = '0;
        for (int k = 0; k < 1040; k++) begin
            r = {r[15:0], (k < 1024) ? dat_ref[k][ln] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    task automatic gen_ref(input int mode);
        for (int k = 0; k < 1024; k++) begin
            if (mode == 0)      dat_ref[k] = 4'h0;
            else if (mode == 1) dat_ref[k] = k[3:0];
            else                dat_ref[k] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic load_mem();
        for (int k = 0; k < 1024; k++) begin
            @(negedge iclk);
            tb_ld = 1'b1; tb_ld_addr = 10'(k); tb_ld_data = dat_ref[k];
        end
        @(negedge iclk);
        tb_ld = 1'b0;
    endtask

    task automatic run_tx(input bit with_rx, input int poke);
        logic [15:0] c [4];
        logic [3:0]  nib;
        for (int i = 0; i < 4; i++) c[i] = crc_ref(i);
        exp_q.delete();
        for (int k = 0; k < NAC; k++) exp_q.push_back(4'hF);
        exp_q.push_back(4'h0);
        for (int k = 0; k < 1024; k++) exp_q.push_back(dat_ref[k]);
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 4; i++) nib[i] = c[i][15-j];
            exp_q.push_back(nib);
        end
        exp_q.push_back(4'hF);
        @(negedge iclk);
        bus.istart_tx = 1'b1; bus.istart_rx = with_rx; wr_clr = 1'b1;
        @(negedge iclk);
        bus.istart_tx = 1'b0; bus.istart_rx = 1'b0; wr_clr = 1'b0;
        chk("tx_fail_clr", 16'(bus.ocrc_fail), 16'h0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge iclk);
            bus.istart_rx = (k == poke);
            chk("tx_dat", 16'(bus.odata_sd), 16'(exp_q[k]));
            chk("tx_done_early", 16'(bus.odone), 16'h0);
        end
        @(negedge iclk);
        bus.istart_rx = 1'b0;
        chk("tx_done", 16'(bus.odone), 16'h1);
        @(negedge iclk);
        chk("tx_done_once", 16'(bus.odone), 16'h0);
        chk("tx_idle", 16'(bus.odata_sd), 16'hF);
        chk("tx_no_write", 16'(wr_cnt), 16'h0);
    endtask

    task automatic run_rx(input int flip_line, input bit bad_end);
        logic [15:0] c [4];
        logic [3:0]  nib;
        logic [2:0]  st;
        logic [3:0]  seq [$];
        bit          exp_fail;
        int          flip_j, nbad;
        exp_fail = (flip_line >= 0) || bad_end;
        flip_j   = $urandom_range(0, 15);
        for (int i = 0; i < 4; i++) c[i] = crc_ref(i);
        @(negedge iclk);
        bus.istart_rx = 1'b1; wr_clr = 1'b1;
        @(negedge iclk);
        bus.istart_rx = 1'b0; wr_clr = 1'b0;
        chk("rx_fail_clr", 16'(bus.ocrc_fail), 16'h0);
        repeat ($urandom_range(0, 3)) @(negedge iclk);
        bus.idata_sd = 4'h0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge iclk);
            bus.idata_sd = dat_ref[k];
        end
        for (int j = 0; j < 16; j++) begin
            @(negedge iclk);
            for (int i = 0; i < 4; i++) nib[i] = c[i][15-j];
            if (j == flip_j && flip_line >= 0) nib[flip_line] = ~nib[flip_line];
            bus.idata_sd = nib;
        end
        @(negedge iclk);
        bus.idata_sd = bad_end ? 4'h7 : 4'hF;
        @(negedge iclk);
        bus.idata_sd = 4'hF;
        st = exp_fail ? 3'b101 : 3'b010;
        seq = '{4'hF, 4'hF, 4'hE, {3'b111, st[2]}, {3'b111, st[1]}, {3'b111, st[0]}, 4'hF};
        for (int k = 0; k < BUSY_EXP; k++) seq.push_back(4'hE);
        chk("rx_fail", 16'(bus.ocrc_fail), 16'(exp_fail));
        for (int k = 0; k < seq.size(); k++) begin
            if (k > 0) @(negedge iclk);
            chk("rx_status", 16'(bus.odata_sd), 16'(seq[k]));
            chk("rx_done_early", 16'(bus.odone), 16'h0);
        end
        @(negedge iclk);
        chk("rx_done", 16'(bus.odone), 16'h1);
        chk("rx_done_dat", 16'(bus.odata_sd), 16'hF);
        @(negedge iclk);
        chk("rx_done_once", 16'(bus.odone), 16'h0);
        chk("rx_write_count", 16'(wr_cnt), 16'd1024);
        nbad = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== dat_ref[k]) nbad++;
        chk("rx_buffer", 16'(nbad), 16'h0);
        chk("rx_fail_hold", 16'(bus.ocrc_fail), 16'(exp_fail));
    endtask

    initial begin
        bus.istart_tx = 1'b0;
        bus.istart_rx = 1'b0;
        bus.idata_sd  = 4'hF;
        repeat (3) @(negedge iclk);
        chk("rst_odata", 16'(bus.odata_sd), 16'hF);
        chk("rst_oaddr", 16'(bus.oaddr), 16'h0);
        chk("rst_owdata", 16'(bus.owdata), 16'h0);
        chk("rst_owrite_en", 16'(bus.owrite_en), 16'h0);
        chk("rst_ocrc_fail", 16'(bus.ocrc_fail), 16'h0);
        chk("rst_odone", 16'(bus.odone), 16'h0);
        irst = 1'b0;

        gen_ref(0); load_mem();
        run_tx(1'b0, -1);

        gen_ref(1); load_mem();
        @(negedge iclk); bus.istart_tx = 1'b1;
        @(negedge iclk); bus.istart_tx = 1'b0;
        repeat (100) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        chk("midrst_odata", 16'(bus.odata_sd), 16'hF);
        chk("midrst_odone", 16'(bus.odone), 16'h0);
        chk("midrst_oaddr", 16'(bus.oaddr), 16'h0);
        irst = 1'b0;
        run_tx(1'b0, -1);

        gen_ref(2); load_mem();
        run_tx(1'b1, 500);
        bus.idata_sd = 4'h0;
        repeat (4) @(negedge iclk);
        chk("contention_rx_ignored", 16'(wr_cnt), 16'h0);
        bus.idata_sd = 4'hF;
        irst = 1'b1;
        @(negedge iclk);
        irst = 1'b0;

        gen_ref(1);
        run_rx(-1, 1'b0);
        run_tx(1'b0, -1);

        gen_ref(2);
        run_rx(2, 1'b0);
        repeat (5) @(negedge iclk);
        chk("fail_sticky", 16'(bus.ocrc_fail), 16'h1);

        gen_ref(2);
        run_rx(-1, 1'b1);
        run_tx(1'b0, -1);

        gen_ref(2);
        run_rx(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
